// File: rtl/secded_pkg.sv
// Shared types and helpers for the SECDED receive path: result record and
// the codeword-to-data-bit mapping.
package secded_pkg;

  localparam int CODE_W = 13;
  localparam int DATA_W = 8;

  // Codeword positions holding data bits, listed from out_data bit 0 upward.
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        syndrome;
    logic              corrected;
    logic              uncorr;
  } secded_res_t;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = code[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/secded_skid_fifo.sv
// Two-entry skid FIFO with registered outputs and a registered in_ready that
// never depends combinationally on out_ready.
module secded_skid_fifo
  import secded_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  secded_res_t in_res,
  output logic        out_valid,
  input  logic        out_ready,
  output secded_res_t out_res
);

  // head_reg drives the outputs directly; tail_reg is the skid slot.
  logic [1:0]  count_reg, count_next;
  secded_res_t head_reg, head_next;
  secded_res_t tail_reg, tail_next;
  logic        ready_reg;
  logic        push, pop;

  assign push = in_valid & ready_reg;
  assign pop  = (count_reg != 2'd0) & out_ready;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case ({push, pop})
      2'b10: begin
        if (count_reg == 2'd0) head_next = in_res;
        else                   tail_next = in_res;
        count_next = count_reg + 2'd1;
      end
      2'b01: begin
        head_next  = tail_reg;
        count_next = count_reg - 2'd1;
      end
      2'b11: begin
        if (count_reg == 2'd1) begin
          head_next = in_res;
        end else begin
          head_next = tail_reg;
          tail_next = in_res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
      ready_reg <= 1'b1;
    end else begin
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      ready_reg <= (count_next < 2'd2);
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_res   = head_reg;

endmodule

// File: rtl/secded_rx_stage.sv
// SECDED receive stage: classifies decoder results, extracts the data byte,
// buffers toward the consumer and keeps saturating error statistics.
module secded_rx_stage
  import secded_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit DROP_UNCORR = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_code,
  input  logic [3:0]       in_syndrome,
  input  logic             in_1bit,
  input  logic             in_2bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorr,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count,
  output logic             uncorr_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  secded_res_t in_res, out_res;
  logic        accept, drop, fifo_in_valid;
  logic        is_corr, is_uncorr;

  // Double-bit flag dominates; a single-bit flag with syndrome 0 is a parity-bit fix.
  assign is_uncorr = in_2bit;
  assign is_corr   = in_1bit & ~in_2bit;

  assign in_res.data      = extract_data(in_code);
  assign in_res.syndrome  = in_syndrome;
  assign in_res.corrected = is_corr;
  assign in_res.uncorr    = is_uncorr;

  assign accept        = in_valid & in_ready;
  assign drop          = DROP_UNCORR & is_uncorr;
  assign fifo_in_valid = in_valid & ~drop;

  secded_skid_fifo u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (fifo_in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  assign out_data      = out_res.data;
  assign out_syndrome  = out_res.syndrome;
  assign out_corrected = out_res.corrected;
  assign out_uncorr    = out_res.uncorr;

  logic [CNT_W-1:0] corr_reg, corr_next;
  logic [CNT_W-1:0] uncorr_reg, uncorr_next;
  logic             sticky_reg, sticky_next;

  always_comb begin
    corr_next   = corr_reg;
    uncorr_next = uncorr_reg;
    sticky_next = sticky_reg;
    if (clear_counts) begin
      corr_next   = '0;
      uncorr_next = '0;
      sticky_next = 1'b0;
    end else if (accept) begin
      if (is_corr && corr_reg != CNT_MAX)     corr_next   = corr_reg + CNT_ONE;
      if (is_uncorr && uncorr_reg != CNT_MAX) uncorr_next = uncorr_reg + CNT_ONE;
      if (is_uncorr)                          sticky_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      corr_reg   <= '0;
      uncorr_reg <= '0;
      sticky_reg <= 1'b0;
    end else begin
      corr_reg   <= corr_next;
      uncorr_reg <= uncorr_next;
      sticky_reg <= sticky_next;
    end
  end

  assign corr_count    = corr_reg;
  assign uncorr_count  = uncorr_reg;
  assign uncorr_sticky = sticky_reg;

endmodule
